// File: rtl/audio_codec_pkg.sv
// ============================================================================
// Module   : audio_codec_pkg
// Purpose  : Shared frame-geometry helpers and LR clock levels for the I2S link.
// Revision : 1.0
// ============================================================================
`default_nettype none

package audio_codec_pkg;

    localparam logic LR_LEFT  = 1'b0;
    localparam logic LR_RIGHT = 1'b1;

    // 32 bit clocks per channel, two channels per frame.
    function automatic int frame_len(input int bclk_div);
        return 64 * bclk_div;
    endfunction

    function automatic int half_len(input int bclk_div);
        return frame_len(bclk_div) / 2;
    endfunction

    // First cycle in which the freshly captured left word is visible.
    function automatic int se_cnt(input int data_width, input int bclk_div);
        return data_width * bclk_div + bclk_div / 2 + 1;
    endfunction

    function automatic int req_cnt(input int bclk_div, input int req_lead);
        return frame_len(bclk_div) - req_lead;
    endfunction

endpackage

`default_nettype wire

// File: rtl/i2s_frame_timer.sv
// ============================================================================
// Module   : i2s_frame_timer
// Purpose  : Frame counter, bit/LR clock generation and per-cycle strobes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module i2s_frame_timer
    import audio_codec_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int BCLK_DIV   = 4,
    parameter int REQ_LEAD   = 8,
    parameter int IW         = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          o_bclk,
    output logic          o_lrck,
    output logic          o_adc_sample_en,
    output logic          o_dac_bit_en,
    output logic [IW-1:0] o_dac_bit_idx,
    output logic          o_se_strobe,
    output logic          o_req_strobe,
    output logic          o_latch_strobe
);

    localparam int c_half   = half_len(BCLK_DIV);
    localparam int c_flen   = frame_len(BCLK_DIV);
    localparam int PW       = $clog2(BCLK_DIV);
    localparam logic [PW-1:0] c_ph_last = PW'(BCLK_DIV - 1);
    localparam logic [PW-1:0] c_ph_mid  = PW'(BCLK_DIV / 2);

    // The frame counter is held as {half, slot, phase}; cnt = half*HALF + slot*BCLK_DIV + phase.
    logic          r_half;
    logic [4:0]    r_slot;
    logic [PW-1:0] r_phase;
    logic          r_bclk;
    logic          r_lrck;

    logic          w_ph_wrap;
    logic          w_half_next;
    logic [4:0]    w_slot_next;
    logic [PW-1:0] w_phase_next;

    function automatic logic hit(input logic h, input logic [4:0] s,
                                 input logic [PW-1:0] p, input int c);
        return (h == (c >= c_half)) &&
               (int'(s) == ((c % c_half) / BCLK_DIV)) &&
               (int'(p) == (c % BCLK_DIV));
    endfunction

    assign w_ph_wrap    = (r_phase == c_ph_last);
    assign w_phase_next = w_ph_wrap ? '0 : r_phase + 1'b1;
    assign w_slot_next  = w_ph_wrap ? r_slot + 5'd1 : r_slot;
    assign w_half_next  = (w_ph_wrap && (r_slot == 5'd31)) ? ~r_half : r_half;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_half  <= 1'b0;
            r_slot  <= '0;
            r_phase <= '0;
            r_bclk  <= 1'b0;
            r_lrck  <= LR_LEFT;
        end else begin
            r_half  <= w_half_next;
            r_slot  <= w_slot_next;
            r_phase <= w_phase_next;
            // Pin levels track the counter value being entered, so they stay aligned with cnt.
            r_bclk  <= (w_phase_next >= c_ph_mid);
            r_lrck  <= w_half_next ? LR_RIGHT : LR_LEFT;
        end
    end

    assign o_bclk = r_bclk;
    assign o_lrck = r_lrck;

    assign o_adc_sample_en = !r_half && (r_slot >= 5'd1) && (r_slot <= 5'(DATA_WIDTH)) &&
                             (r_phase == c_ph_mid);

    // Data slots are judged on the upcoming slot so the registered pin changes on the BCLK fall.
    assign o_dac_bit_en  = (w_slot_next >= 5'd1) && (w_slot_next <= 5'(DATA_WIDTH));
    assign o_dac_bit_idx = IW'(DATA_WIDTH - int'(w_slot_next));

    assign o_se_strobe    = hit(r_half, r_slot, r_phase, se_cnt(DATA_WIDTH, BCLK_DIV) - 1);
    assign o_req_strobe   = hit(r_half, r_slot, r_phase, req_cnt(BCLK_DIV, REQ_LEAD) - 1);
    assign o_latch_strobe = hit(r_half, r_slot, r_phase, c_flen - 1);

endmodule

`default_nettype wire

// File: rtl/audio_codec_if.sv
// ============================================================================
// Module   : audio_codec_if
// Purpose  : Master-mode I2S bridge between the board codec and filter_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module audio_codec_if
    import audio_codec_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int BCLK_DIV   = 4,
    parameter int REQ_LEAD   = 8
) (
    input  logic                  audio_clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] audio_output,
    output logic [DATA_WIDTH-1:0] audio_input,
    output logic                  sample_end,
    output logic                  sample_req,
    output logic                  AUD_BCLK,
    output logic                  AUD_DACLRCK,
    output logic                  AUD_ADCLRCK,
    output logic                  AUD_DACDAT,
    input  logic                  AUD_ADCDAT
);

    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic          w_bclk;
    logic          w_lrck;
    logic          w_adc_sample_en;
    logic          w_dac_bit_en;
    logic [IW-1:0] w_dac_bit_idx;
    logic          w_se_strobe;
    logic          w_req_strobe;
    logic          w_latch_strobe;

    logic [DATA_WIDTH-1:0] r_dac_word;
    logic [DATA_WIDTH-2:0] r_adc_shift;
    logic [DATA_WIDTH-1:0] r_audio_input;
    logic                  r_sample_end;
    logic                  r_sample_req;
    logic                  r_dacdat;
    logic [DATA_WIDTH-1:0] w_adc_shift_next;

    i2s_frame_timer #(
        .DATA_WIDTH (DATA_WIDTH),
        .BCLK_DIV   (BCLK_DIV),
        .REQ_LEAD   (REQ_LEAD),
        .IW         (IW)
    ) u_timer (
        .clk             (audio_clk),
        .rst_n           (reset_n),
        .o_bclk          (w_bclk),
        .o_lrck          (w_lrck),
        .o_adc_sample_en (w_adc_sample_en),
        .o_dac_bit_en    (w_dac_bit_en),
        .o_dac_bit_idx   (w_dac_bit_idx),
        .o_se_strobe     (w_se_strobe),
        .o_req_strobe    (w_req_strobe),
        .o_latch_strobe  (w_latch_strobe)
    );

    assign w_adc_shift_next = {r_adc_shift, AUD_ADCDAT};

    // The sample_end edge coincides with the last-bit sample, so the capture takes the
    // word including that bit; only DATA_WIDTH-1 earlier bits need to be held.
    always_ff @(posedge audio_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dac_word    <= '0;
            r_adc_shift   <= '0;
            r_audio_input <= '0;
            r_sample_end  <= 1'b0;
            r_sample_req  <= 1'b0;
            r_dacdat      <= 1'b0;
        end else begin
            if (w_adc_sample_en) begin
                r_adc_shift <= w_adc_shift_next[DATA_WIDTH-2:0];
            end
            if (w_se_strobe) begin
                r_audio_input <= w_adc_shift_next;
            end
            if (w_latch_strobe) begin
                r_dac_word <= audio_output;
            end
            r_sample_end <= w_se_strobe;
            r_sample_req <= w_req_strobe;
            r_dacdat     <= w_dac_bit_en ? r_dac_word[w_dac_bit_idx] : 1'b0;
        end
    end

    assign audio_input = r_audio_input;
    assign sample_end  = r_sample_end;
    assign sample_req  = r_sample_req;
    assign AUD_BCLK    = w_bclk;
    assign AUD_DACLRCK = w_lrck;
    assign AUD_ADCLRCK = w_lrck;
    assign AUD_DACDAT  = r_dacdat;

endmodule

`default_nettype wire

// File: tb/tb_audio_codec_if.sv
// ============================================================================
// Module   : tb_audio_codec_if
// Purpose  : Scoreboard bench for audio_codec_if with a behavioural I2S codec.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_audio_codec_if;

    logic        audio_clk = 1'b0;
    logic        reset_n   = 1'b0;
    logic [15:0] audio_output;
    logic [15:0] audio_input;
    logic        sample_end;
    logic        sample_req;
    logic        AUD_BCLK;
    logic        AUD_DACLRCK;
    logic        AUD_ADCLRCK;
    logic        AUD_DACDAT;
    logic        AUD_ADCDAT = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    audio_codec_if #(.DATA_WIDTH(16), .BCLK_DIV(4), .REQ_LEAD(8)) dut (
        .audio_clk    (audio_clk),
        .reset_n      (reset_n),
        .audio_output (audio_output),
        .audio_input  (audio_input),
        .sample_end   (sample_end),
        .sample_req   (sample_req),
        .AUD_BCLK     (AUD_BCLK),
        .AUD_DACLRCK  (AUD_DACLRCK),
        .AUD_ADCLRCK  (AUD_ADCLRCK),
        .AUD_DACDAT   (AUD_DACDAT),
        .AUD_ADCDAT   (AUD_ADCDAT)
    );

    always #5 audio_clk = ~audio_clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference frame position, kept independently of the design.
    int   tb_cnt  = 0;
    logic tb_wrap = 1'b0;
    always @(posedge audio_clk or negedge reset_n) begin
        if (!reset_n) begin
            tb_cnt  <= 0;
            tb_wrap <= 1'b0;
        end else begin
            tb_wrap <= (tb_cnt == 255);
            tb_cnt  <= (tb_cnt == 255) ? 0 : tb_cnt + 1;
        end
    end

    logic [15:0] sine_tab [100];
    initial begin
        for (int i = 0; i < 100; i++)
            sine_tab[i] = 16'($rtoi(30000.0 * $sin(6.283185307 * real'(i) / 100.0)));
    end

    // Behavioural codec: ADC word MSB in the slot after each LRCK edge.
    logic [15:0] adc_left  = 16'h7fb7;
    logic [15:0] adc_right = 16'hffff;
    logic        loop_en   = 1'b0;
    logic [15:0] codec_cur = 16'h0;
    logic [15:0] codec_word;
    logic        prev_lr   = 1'b0;
    int          bitcnt    = 0;
    int          sidx      = 0;
    logic [15:0] adc_exp_q [$];
    logic [15:0] dac_q [$];

    always @(negedge AUD_BCLK or negedge reset_n) begin
        #1;
        if (!reset_n) begin
            bitcnt     = 0;
            prev_lr    = 1'b0;
            AUD_ADCDAT = 1'b0;
        end else begin
            if (AUD_DACLRCK != prev_lr) bitcnt = 0;
            else                        bitcnt++;
            prev_lr = AUD_DACLRCK;
            if (!AUD_DACLRCK && bitcnt == 1) begin
                if (loop_en) begin
                    codec_cur = sine_tab[sidx];
                    sidx      = (sidx + 1) % 100;
                end else begin
                    codec_cur = adc_left;
                end
                adc_exp_q.push_back(codec_cur);
            end
            codec_word = AUD_DACLRCK ? adc_right : codec_cur;
            AUD_ADCDAT = (bitcnt >= 1 && bitcnt <= 16) ? codec_word[16 - bitcnt] : 1'b0;
        end
    end

    // Monitor: pin timing, DAC serial stream and the audio_input scoreboard.
    logic [15:0] last_pres = 16'h0;
    logic [15:0] cur_dac   = 16'h0;
    int          slot;
    always @(negedge audio_clk) begin
        if (!reset_n) begin
            cur_dac = 16'h0;
            adc_exp_q.delete();
        end else begin
            if (tb_wrap) begin
                if (dac_q.size() > 0) last_pres = dac_q.pop_front();
                cur_dac = last_pres;
            end
            slot = (tb_cnt % 128) / 4;
            check("bclk",        32'(AUD_BCLK),    32'((tb_cnt % 4) >= 2));
            check("daclrck",     32'(AUD_DACLRCK), 32'(tb_cnt >= 128));
            check("adclrck",     32'(AUD_ADCLRCK), 32'(tb_cnt >= 128));
            check("sample_req",  32'(sample_req),  32'(tb_cnt == 248));
            check("sample_end",  32'(sample_end),  32'(tb_cnt == 67));
            check("dacdat",      32'(AUD_DACDAT),
                  32'((slot >= 1 && slot <= 16) ? cur_dac[16 - slot] : 1'b0));
            if (sample_end) begin
                if (adc_exp_q.size() == 0)
                    check("sample_end_unexpected", 32'(1), 32'(0));
                else
                    check("audio_input", 32'(audio_input), 32'(adc_exp_q.pop_front()));
            end
        end
    end

    task automatic outs_zero(input string nm);
        check(nm, {audio_input, sample_end, sample_req, AUD_BCLK, AUD_DACLRCK,
                   AUD_ADCLRCK, AUD_DACDAT}, 32'h0);
    endtask

    task automatic wait_cnt(input int c);
        for (int i = 0; i < 600; i++) begin
            @(negedge audio_clk);
            if (tb_cnt == c) return;
        end
        check("timeout_cnt", 32'(0), 32'(1));
    endtask

    task automatic wait_req();
        for (int i = 0; i < 600; i++) begin
            @(negedge audio_clk);
            if (sample_req) return;
        end
        check("timeout_req", 32'(0), 32'(1));
    endtask

    task automatic count_to_se(output int n);
        n = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge audio_clk);
            n++;
            if (sample_end) return;
        end
        check("timeout_se", 32'(0), 32'(1));
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1);
    end

    initial begin
        int n;
        audio_output = 16'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge audio_clk);
            outs_zero("reset_hold");
        end
        #2 reset_n = 1'b1;

        count_to_se(n);
        check("first_se_latency", 32'(n), 32'(67));
        for (int i = 0; i < 600 && !sample_req; i++) begin
            @(negedge audio_clk);
            n++;
        end
        check("first_req_cycle", 32'(n), 32'(248));

        // Word presented three cycles after the request plays in the next frame.
        repeat (3) @(negedge audio_clk);
        audio_output = 16'hf629;
        dac_q.push_back(16'hf629);

        wait_req();
        audio_output = 16'h0805;
        dac_q.push_back(16'h0805);

        // A late change must not disturb the frame already playing.
        wait_cnt(10);
        audio_output = 16'h1002;
        dac_q.push_back(16'h1002);

        wait_req();
        wait_cnt(40);
        #2 reset_n = 1'b0;
        #1 outs_zero("async_clear");
        @(negedge audio_clk);
        #2 reset_n = 1'b1;
        count_to_se(n);
        check("post_reset_se_latency", 32'(n), 32'(67));

        wait_cnt(100);
        loop_en = 1'b1;
        for (int f = 0; f < 200; f++) begin
            count_to_se(n);
            audio_output = audio_input;
            dac_q.push_back(codec_cur);
        end
        repeat (600) @(negedge audio_clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/audio_codec_if.md
Name: audio_codec_if

Overview:
- Codec-side end of the sample_end / sample_req audio handshake consumed by filter_ctrl.
- Master-mode I2S interface to the board codec:
  - generates the bit clock and both LR clocks from audio_clk;
  - deserialises the ADC left-channel word to audio_input and pulses sample_end;
  - pulses sample_req ahead of each frame and serialises audio_output to the DAC on both channels (mono).
- Sits between the codec pins and filter_ctrl, entirely in the audio_clk domain (11.2896 MHz, 44.1 kHz frames).

Parameters:
- DATA_WIDTH, 16, sample width in bits (max 31).
- BCLK_DIV, 4, audio_clk cycles per bit-clock period (even, >=4).
- REQ_LEAD, 8, audio_clk cycles from sample_req to the DAC word latch (>=2).

Ports:
- audio_clk  in  1  block clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- audio_output  in  DATA_WIDTH  sample to play; latched once per frame.
- audio_input  out  DATA_WIDTH  last captured ADC left sample.
- sample_end  out  1  one-cycle pulse: audio_input has just been updated.
- sample_req  out  1  one-cycle pulse: present the next audio_output.
- AUD_BCLK  out  1  I2S bit clock.
- AUD_DACLRCK  out  1  DAC LR clock (0 = left).
- AUD_ADCLRCK  out  1  ADC LR clock; identical to AUD_DACLRCK.
- AUD_DACDAT  out  1  serial DAC data, MSB first.
- AUD_ADCDAT  in  1  serial ADC data, MSB first.

Behaviour:
- Frame counter cnt runs 0..FRAME_LEN-1 and wraps to 0.
  - FRAME_LEN = 64*BCLK_DIV (256 at defaults).
  - HALF = FRAME_LEN/2.
  - Bit slot s = (cnt mod HALF) / BCLK_DIV.
  - Phase p = cnt mod BCLK_DIV.
- Reset (async assert, sync release):
  - cnt=0, AUD_BCLK=0, both LRCKs=0, AUD_DACDAT=0.
  - sample_end=0, sample_req=0, audio_input=0, dac_word=0, adc_shift=0.
  - Reset mid-frame abandons the partial frame. The first sample_end after release occurs at cnt=SE_CNT of the first frame.
- AUD_BCLK: registered; low for p < BCLK_DIV/2, high otherwise.
- LRCK: registered; 0 for cnt < HALF, 1 otherwise. It changes together with a BCLK falling edge.
- I2S framing: bit k (k=0 is MSB) of each channel occupies slot s=k+1, i.e. one bit clock after the LRCK edge. Slots 0 and DATA_WIDTH+1..31 are idle.
- DAC path:
  - Registered AUD_DACDAT equals dac_word[DATA_WIDTH-1-k] throughout slot k+1 of both halves, and 0 in idle slots.
  - Changes coincide with BCLK falling edges.
- ADC capture:
  - On the edge ending a cycle with cnt<HALF, s in 1..DATA_WIDTH and p = BCLK_DIV/2, adc_shift <= {adc_shift, AUD_ADCDAT}. This samples mid-high of BCLK.
  - The right half is ignored.
- sample_end:
  - SE_CNT = DATA_WIDTH*BCLK_DIV + BCLK_DIV/2 + 1 (67 at defaults).
  - On the edge ending cnt=SE_CNT-1, audio_input <= adc_shift and sample_end <= 1.
  - sample_end is high for exactly the cycle cnt=SE_CNT.
  - audio_input holds until the next frame.
- sample_req: high for exactly the cycle cnt = FRAME_LEN-REQ_LEAD (248 at defaults).
- DAC latch:
  - On the edge ending cnt=FRAME_LEN-1, dac_word <= audio_output.
  - The requester has REQ_LEAD-1 cycles after sample_req; audio_output values at other times are ignored.
  - The latched word plays in both halves of the new frame.
- Pulse spacing: sample_end and sample_req are never simultaneous, and each occurs exactly once per FRAME_LEN cycles.
- No back-pressure: a missing response simply replays stale audio_output.

Decomposition:
- Package audio_codec_pkg holds:
  - FRAME_LEN / HALF derivation functions;
  - SE_CNT and REQ_CNT computation functions;
  - LR_LEFT=0 / LR_RIGHT=1 constants.
- One sub-module, i2s_frame_timer: owns cnt, AUD_BCLK, LRCK, slot/phase decode, and the one-cycle strobes (adc_sample_en, dac_bit_en, se_strobe, req_strobe, latch_strobe).
- Top level holds the shift registers and the sample_end, sample_req and audio_input registers.

Test Plan:
- Reset held 3 cycles, then released:
  - all outputs 0 while held;
  - AUD_BCLK toggles every 2 cycles;
  - LRCK rises at cnt=128;
  - first sample_end 67 cycles after release;
  - sample_req at cycle 248.
- Behavioural codec model drives ADC left 16'h7fb7 and right 16'hffff:
  - audio_input = 16'h7fb7 in the sample_end cycle;
  - right word ignored.
- audio_output = 16'hf629 presented 3 cycles after sample_req:
  - next frame AUD_DACDAT shifts 1111011000101001 on BCLK slots 1..16 of both halves;
  - slot 0 and slots 17..31 are 0.
- audio_output changed from 16'h0805 to 16'h1002 at cnt=10: the current frame still plays 16'h0805.
- reset_n pulsed low at cnt=40 for 1 cycle:
  - outputs clear asynchronously;
  - no sample_end in that frame;
  - next sample_end exactly 67 cycles after release.
- 200 frames looping the 100-entry sine table through an ADC-to-DAC loopback: each DAC word equals the ADC word captured in the previous frame.
